// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//
// Control FSM for a multicycle MIPS datapath. Sequences instruction fetch,
// decode and the per-class execute/writeback states, drives the ALU opcode
// and operand selects, and strobes memory, IR, PC and register file.
//
// Parameters
//   WAIT_LIMIT  max consecutive mem_ready-low cycles in FETCH/MEMRD/MEMWR
//               before the access is abandoned (0 = wait forever)
//
// Configuration macro
//   MC_CTRL_ILLEGAL_TRAP_EN  defined: illegal opcode/funct parks the FSM in
//                            TRAP with illegal_op high until rst.
//                            undefined: illegal instructions act as a NOP.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   opcode, funct             IR[31:26], IR[5:0]
//   zero_flag                 ALU zero result (branch decision)
//   mem_ready                 memory access completes this cycle
//   alu_control               ALU opcode
//   alu_src_a, alu_src_b      ALU operand selects
//   iord                      memory address select (PC / ALUOut)
//   mem_read, mem_write       memory requests
//   ir_write, pc_write        IR / PC load strobes
//   pc_src                    next-PC select
//   reg_write, reg_dst,
//   mem_to_reg                register-file write strobe and selects
//   timeout                   one-cycle pulse when a memory wait is abandoned
//   illegal_op                high while parked in TRAP
//   state_dbg                 current state encoding
// ---------------------------------------------------------------------------
module mc_control_unit #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       timeout,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_IMM_EX   = 4'd9;
  localparam logic [3:0] S_IMM_WB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // Where an illegal opcode or funct sends the FSM
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_ILLEGAL  = S_TRAP;
`else
  localparam logic [3:0] S_ILLEGAL  = S_FETCH;
`endif

  // ALU opcodes (1000 is LUI, so multiply is never issued)
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_REM = 4'b1011;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Wait counter sizing; holds values 0..WAIT_LIMIT-1
  localparam int              CNT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             wait_expired;
  logic [3:0]       rtype_alu;
  logic             funct_legal;

  // A memory-wait state whose access did not complete this cycle
  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                   && !mem_ready;

  // The limit cycle is the one where the count already equals WAIT_LIMIT-1
  // and memory is still not ready; mem_ready in that cycle wins.
  assign wait_expired = (WAIT_LIMIT > 0) && waiting && (wait_cnt == CNT_LAST);

  // R-type funct decode
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    rtype_alu   = ALU_AND;
    funct_legal = 1'b1;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b100111: rtype_alu = ALU_NOR;
      6'b101010: rtype_alu = ALU_SLT;
      6'b011010: rtype_alu = ALU_DIV;
      6'b011011: rtype_alu = ALU_REM;
      default:   funct_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)         state_next = S_DECODE;
        else if (wait_expired) state_next = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    state_next = S_MEMADR;
          OP_RTYPE:        state_next = S_RTYPE_EX;
          OP_BEQ:          state_next = S_BRANCH;
          OP_ADDI, OP_LUI: state_next = S_IMM_EX;
          OP_J:            state_next = S_JUMP;
          default:         state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)         state_next = S_MEMWB;
        else if (wait_expired) state_next = S_FETCH;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || wait_expired) state_next = S_FETCH;
      end
      S_RTYPE_EX: state_next = funct_legal ? S_ALU_WB : S_ILLEGAL;
      S_ALU_WB:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_IMM_EX:   state_next = S_IMM_WB;
      S_IMM_WB:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((WAIT_LIMIT == 0) || (state_next != state) || wait_expired)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Moore outputs, with the FETCH and BRANCH qualifications
  always_comb begin
    alu_control = ALU_AND;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    timeout     = wait_expired;
    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a   = 1'b1;
        alu_control = rtype_alu;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = zero_flag;
      end
      S_IMM_EX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = (opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_TRAP: begin
        timeout = 1'b0;
      end
      default: ;
    endcase

    // Strobes are forced low while rst is high so nothing commits in the
    // reset cycle, even with mem_ready asserted in FETCH.
    if (rst) begin
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      timeout   = 1'b0;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_TRAP) && !rst;
`else
  assign illegal_op = 1'b0;
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
//
// Directed bench for mc_control_unit built with WAIT_LIMIT = 3. Each step
// drives inputs just after a rising edge, pushes the expected state and
// output vector to a scoreboard, and pops/compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       timeout;
    logic       illegal_op;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       timeout;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  mc_control_unit #(.WAIT_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .timeout(timeout), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  outs_t obs;
  assign obs = {alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
                timeout, illegal_op};

  // Expected outputs per state, written from the state descriptions
  function automatic outs_t f_fetch(input logic mr);
    outs_t o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_control = 4'b0010;
    o.ir_write = mr;   o.pc_write  = mr;
    return o;
  endfunction
  function automatic outs_t f_decode();
    outs_t o = '0;
    o.alu_src_b = 2'b11; o.alu_control = 4'b0010;
    return o;
  endfunction
  function automatic outs_t f_memadr();
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = 4'b0010;
    return o;
  endfunction
  function automatic outs_t f_memrd();
    outs_t o = '0;
    o.mem_read = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_memwb();
    outs_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_memwr(input logic to);
    outs_t o = '0;
    o.mem_write = 1'b1; o.iord = 1'b1; o.timeout = to;
    return o;
  endfunction
  function automatic outs_t f_rtype(input logic [3:0] alu);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_control = alu;
    return o;
  endfunction
  function automatic outs_t f_aluwb();
    outs_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_branch(input logic z);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_control = 4'b0110; o.pc_src = 2'b01; o.pc_write = z;
    return o;
  endfunction
  function automatic outs_t f_immex(input logic [3:0] alu);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = alu;
    return o;
  endfunction
  function automatic outs_t f_immwb();
    outs_t o = '0;
    o.reg_write = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_jump();
    outs_t o = '0;
    o.pc_src = 2'b10; o.pc_write = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_trap();
    outs_t o = '0;
    o.illegal_op = 1'b1;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic zf, input logic mr,
                      input logic [3:0] st, input outs_t o);
    exp_t e;
    opcode = op; funct = fn; zero_flag = zf; mem_ready = mr;
    sb.push_back('{st: st, o: o});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "/state"}, 32'(state_dbg), 32'(e.st));
    check({tag, "/outs"},  32'(obs),       32'(e.o));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check({tag, "/state"}, 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, LUI = 6'b001111,
                         J = 6'b000010, BAD = 6'b111111;

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: FETCH selects, strobes held low despite mem_ready
    check("reset/state", 32'(state_dbg), 32'd0);
    check("reset/outs",  32'(obs),       32'(f_fetch(1'b0)));
    rst = 1'b0;

    // lw with two wait cycles in MEMRD; third MEMRD cycle is the limit cycle
    step("lw_fetch",  LW, 6'd0, 0, 1, 4'd0, f_fetch(1'b1));
    step("lw_dec",    LW, 6'd0, 0, 1, 4'd1, f_decode());
    step("lw_adr",    LW, 6'd0, 0, 1, 4'd2, f_memadr());
    step("lw_rd0",    LW, 6'd0, 0, 0, 4'd3, f_memrd());
    step("lw_rd1",    LW, 6'd0, 0, 0, 4'd3, f_memrd());
    step("lw_rd2",    LW, 6'd0, 0, 1, 4'd3, f_memrd());
    step("lw_wb",     LW, 6'd0, 0, 1, 4'd4, f_memwb());

    // sub, with two FETCH wait cycles first
    step("sub_fw0",   RT, 6'b100010, 0, 0, 4'd0, f_fetch(1'b0));
    step("sub_fw1",   RT, 6'b100010, 0, 0, 4'd0, f_fetch(1'b0));
    step("sub_fetch", RT, 6'b100010, 0, 1, 4'd0, f_fetch(1'b1));
    step("sub_dec",   RT, 6'b100010, 0, 1, 4'd1, f_decode());
    step("sub_ex",    RT, 6'b100010, 0, 1, 4'd6, f_rtype(4'b0110));
    step("sub_wb",    RT, 6'b100010, 0, 1, 4'd7, f_aluwb());

    // slt and nor execute opcodes
    step("slt_fetch", RT, 6'b101010, 0, 1, 4'd0, f_fetch(1'b1));
    step("slt_dec",   RT, 6'b101010, 0, 1, 4'd1, f_decode());
    step("slt_ex",    RT, 6'b101010, 0, 1, 4'd6, f_rtype(4'b0111));
    step("slt_wb",    RT, 6'b101010, 0, 1, 4'd7, f_aluwb());

    // beq taken, then not taken
    step("beq1_fetch", BEQ, 6'd0, 1, 1, 4'd0, f_fetch(1'b1));
    step("beq1_dec",   BEQ, 6'd0, 1, 1, 4'd1, f_decode());
    step("beq1_br",    BEQ, 6'd0, 1, 1, 4'd8, f_branch(1'b1));
    step("beq0_fetch", BEQ, 6'd0, 0, 1, 4'd0, f_fetch(1'b1));
    step("beq0_dec",   BEQ, 6'd0, 0, 1, 4'd1, f_decode());
    step("beq0_br",    BEQ, 6'd0, 0, 1, 4'd8, f_branch(1'b0));

    // lui and addi
    step("lui_fetch",  LUI, 6'd0, 0, 1, 4'd0,  f_fetch(1'b1));
    step("lui_dec",    LUI, 6'd0, 0, 1, 4'd1,  f_decode());
    step("lui_ex",     LUI, 6'd0, 0, 1, 4'd9,  f_immex(4'b1000));
    step("lui_wb",     LUI, 6'd0, 0, 1, 4'd10, f_immwb());
    step("addi_fetch", ADDI, 6'd0, 0, 1, 4'd0,  f_fetch(1'b1));
    step("addi_dec",   ADDI, 6'd0, 0, 1, 4'd1,  f_decode());
    step("addi_ex",    ADDI, 6'd0, 0, 1, 4'd9,  f_immex(4'b0010));
    step("addi_wb",    ADDI, 6'd0, 0, 1, 4'd10, f_immwb());

    // jump
    step("j_fetch", J, 6'd0, 0, 1, 4'd0,  f_fetch(1'b1));
    step("j_dec",   J, 6'd0, 0, 1, 4'd1,  f_decode());
    step("j_jump",  J, 6'd0, 0, 1, 4'd11, f_jump());

    // sw timing out: timeout on the 3rd wait cycle, then FETCH
    step("sw_fetch", SW, 6'd0, 0, 1, 4'd5 - 4'd5, f_fetch(1'b1));
    step("sw_dec",   SW, 6'd0, 0, 1, 4'd1, f_decode());
    step("sw_adr",   SW, 6'd0, 0, 1, 4'd2, f_memadr());
    step("sw_w0",    SW, 6'd0, 0, 0, 4'd5, f_memwr(1'b0));
    step("sw_w1",    SW, 6'd0, 0, 0, 4'd5, f_memwr(1'b0));
    step("sw_w2",    SW, 6'd0, 0, 0, 4'd5, f_memwr(1'b1));
    step("sw_after", SW, 6'd0, 0, 0, 4'd0, f_fetch(1'b0));

    // Illegal opcode
    step("bad_fetch", BAD, 6'd0, 0, 1, 4'd0, f_fetch(1'b1));
    step("bad_dec",   BAD, 6'd0, 0, 1, 4'd1, f_decode());
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    step("bad_trap0", BAD, 6'd0, 0, 1, 4'd12, f_trap());
    step("bad_trap1", BAD, 6'd0, 1, 1, 4'd12, f_trap());
`else
    step("bad_nop",   BAD, 6'd0, 0, 0, 4'd0, f_fetch(1'b0));
`endif
    reset_pulse("trap_rst");

    // Illegal funct
    step("badf_fetch", RT, 6'b111111, 0, 1, 4'd0, f_fetch(1'b1));
    step("badf_dec",   RT, 6'b111111, 0, 1, 4'd1, f_decode());
    step("badf_ex",    RT, 6'b111111, 0, 1, 4'd6, f_rtype(4'b0000));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    step("badf_trap",  RT, 6'b111111, 0, 1, 4'd12, f_trap());
`else
    step("badf_nop",   RT, 6'b111111, 0, 0, 4'd0, f_fetch(1'b0));
`endif
    reset_pulse("badf_rst");

    // rst asserted mid-MEMWR aborts the write at once
    step("swr_fetch", SW, 6'd0, 0, 1, 4'd0, f_fetch(1'b1));
    step("swr_dec",   SW, 6'd0, 0, 1, 4'd1, f_decode());
    step("swr_adr",   SW, 6'd0, 0, 1, 4'd2, f_memadr());
    mem_ready = 1'b0;
    #1 check("swr_wr/state", 32'(state_dbg), 32'd5);
    check("swr_wr/outs", 32'(obs), 32'(f_memwr(1'b0)));
    rst = 1'b1; mem_ready = 1'b1;
    #1 check("swr_rst/state", 32'(state_dbg), 32'd0);
    check("swr_rst/outs", 32'(obs), 32'(f_fetch(1'b0)));
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_fetch", J, 6'd0, 0, 1, 4'd0, f_fetch(1'b1));
    step("post_dec",   J, 6'd0, 0, 1, 4'd1, f_decode());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
